hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard-detection and forwarding controller for the MIPS pipeline. It tracks in-flight register writers across the post-ID stages (EXE, MEM, WB for DEPTH=3) and generates stall, flush and per-operand forwarding selects. Selects are registered into EXE alongside the instruction. The block replaces the open hazard/forwarding slots of the MIPS top and generalises them in register count and pipeline depth. It adds branch-operand stalls and a stall counter.

## Interface
- REG_ADDR_W, 5, register index width
- DEPTH, 3, tracked post-ID stages; entry 0 = EXE, entry DEPTH-1 = WB; legal 2..8
- SEL_W, $clog2(DEPTH), forwarding select width
- CNT_W, 32, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_ADDR_W  ID source registers (rs, rt)
- id_use1, id_use2  in  1  source actually read
- id_dst  in  REG_ADDR_W  ID destination register
- id_wb_en  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load
- id_is_br  in  1  ID instruction is BEQ/BNE, compared in ID
- br_taken  in  1  branch/jump resolved taken in ID
- stall  out  1  hold PC and IF/ID; inject bubble into ID/EXE
- flush  out  1  clear IF/ID
- fwd_sel1, fwd_sel2  out  SEL_W  EXE operand source: 0 = ID/EXE register, k = result of stage k (1 = MEM ALU result, 2 = WB result)
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard: DEPTH entries {valid, dst, is_load}. Shift toward WB every cycle; entry DEPTH-1 is dropped.
- Entry 0 load: valid = id_valid & ~stall & id_wb_en & (id_dst != 0); otherwise a bubble (all zero).
- Match: source used, source != 0, and entry valid with equal dst. The nearest (lowest index) match wins.
- The register file is write-through, so a match only in entry DEPTH-1 needs no action.
- Load-use: an ALU/store source matches entry 0 with is_load -> stall = 1.
- Branch: id_is_br and a source matches any entry 0..DEPTH-2 -> stall = 1. There is no forwarding into ID.
- Forward: nearest match at entry i (i ≤ DEPTH-2), not a stall case -> next fwd_selN = i+1.
- No match -> next fwd_selN = 0.
- flush = br_taken & ~stall & id_valid.
- While stall = 1, the next fwd_sel values are 0, since a bubble enters EXE.
- stall_cnt increments on every stall cycle and saturates at all-ones.

## Timing
- stall and flush are combinational from ID inputs and scoreboard state, within the same cycle.
- fwd_sel1/2 are registered with 1-cycle latency and are valid for the cycle the instruction occupies EXE.
- A load-use stall lasts exactly 1 cycle. A branch stall persists until the producer reaches entry DEPTH-1 (at most DEPTH-1 cycles).
- Reset:
  - all entries invalid
  - fwd_sel1/2 = 0
  - stall_cnt = 0
  - stall = 0 and flush = 0 in the first cycle after reset (scoreboard empty, absent br_taken)
- rst during a stall: the scoreboard clears in the same edge, and stall deasserts in the next cycle.
- stall and br_taken in the same cycle: stall wins and flush = 0. The branch re-evaluates once the stall ends.
- Both sources match different entries: each select is resolved independently.
- src1 == src2: both selects are equal.

## Configuration
- HAZARD_FWD_EN defined: forwarding and load-use behaviour as described above.
- HAZARD_FWD_EN undefined:
  - fwd_sel1/2 are tied to 0.
  - Any used-source match in entries 0..DEPTH-2 stalls, whether or not the instruction is a branch.
  - The stall is held until the producer reaches entry DEPTH-1.

## Structure
- The shared definitions file (configs.v) holds:
  - the register-address width
  - the select encodings (SEL_RF = 0, SEL_MEM = 1, SEL_WB = 2)
  - the stall-counter width default
- Sub-module sb_match: combinational priority finder over DEPTH entries. It returns {hit, index, is_load} for one source and is instantiated twice.

## Test plan
1. add $3,$1,$2 then add $4,$3,$3 (no gap) -> stall = 0. Next cycle fwd_sel1 = fwd_sel2 = 1.
2. lw $5,0($0) then add $6,$5,$1 -> one stall cycle with stall_cnt = 1. Bubble enters EXE. After the stall, the next fwd_sel1 = 2.
3. add $7,… then beq $7,$0 -> stall for 2 cycles, then flush = 1 if br_taken. No flush is asserted during the stall.
4. add $0,$1,$2 then add $8,$0,$0 -> no stall, fwd_sel = 0 (register 0 is ignored).
5. rst asserted mid-stall after lw/use -> all outputs are 0 on the next cycle and the scoreboard is empty.
6. HAZARD_FWD_EN undefined, scenario 1 -> stall = 1 for 2 cycles, fwd_sel stays 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared widths, forwarding select encodings and stall causes
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 32;

    localparam int SEL_RF  = 0;
    localparam int SEL_MEM = 1;
    localparam int SEL_WB  = 2;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_LOAD_USE,
        CAUSE_BRANCH,
        CAUSE_RAW
    } stall_cause_e;

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// rtl/hazard_scoreboard_sb_match.sv - nearest-entry priority finder for one source operand
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic [REG_ADDR_W-1:0]       src,
    input  logic                        src_used,
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [DEPTH*REG_ADDR_W-1:0] ent_dst,
    input  logic [DEPTH-1:0]            ent_is_load,
    output logic                        hit,
    output logic [SEL_W-1:0]            index,
    output logic                        is_load
);

    // Scan from the oldest entry down so the youngest (lowest index) producer wins.
    always_comb begin
        hit     = 1'b0;
        index   = '0;
        is_load = 1'b0;
        if (src_used && (src != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (ent_valid[i] && (ent_dst[i*REG_ADDR_W +: REG_ADDR_W] == src)) begin
                    hit     = 1'b1;
                    index   = SEL_W'(i);
                    is_load = ent_is_load[i];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - hazard scoreboard and stall/flush/forward control; HAZARD_FWD_EN enables EXE forwarding
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = $clog2(DEPTH),
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wb_en,
    input  logic                  id_is_load,
    input  logic                  id_is_br,
    input  logic                  br_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int LAST = DEPTH - 1;

    logic [DEPTH-1:0]            sb_valid;
    logic [DEPTH-1:0]            sb_is_load;
    logic [DEPTH*REG_ADDR_W-1:0] sb_dst;

    logic             hit1, hit2, ld1, ld2;
    logic [SEL_W-1:0] idx1, idx2;
    logic             act1, act2, load_use, push;
    stall_cause_e     cause;

    sb_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match1 (
        .src(id_src1), .src_used(id_use1),
        .ent_valid(sb_valid), .ent_dst(sb_dst), .ent_is_load(sb_is_load),
        .hit(hit1), .index(idx1), .is_load(ld1)
    );

    sb_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match2 (
        .src(id_src2), .src_used(id_use2),
        .ent_valid(sb_valid), .ent_dst(sb_dst), .ent_is_load(sb_is_load),
        .hit(hit2), .index(idx2), .is_load(ld2)
    );

    // A producer in the last entry writes the register file this cycle, which ID reads through.
    assign act1     = hit1 && (idx1 != SEL_W'(LAST));
    assign act2     = hit2 && (idx2 != SEL_W'(LAST));
    assign load_use = (act1 && (idx1 == '0) && ld1) || (act2 && (idx2 == '0) && ld2);

`ifdef HAZARD_FWD_EN
    always_comb begin
        cause = CAUSE_NONE;
        if (id_valid) begin
            if (load_use)
                cause = CAUSE_LOAD_USE;
            else if (id_is_br && (act1 || act2))
                cause = CAUSE_BRANCH;
        end
    end
`else
    // Without forwarding every live dependency waits for the write-through stage.
    always_comb begin
        cause = CAUSE_NONE;
        if (id_valid && (act1 || act2)) begin
            if (load_use)
                cause = CAUSE_LOAD_USE;
            else if (id_is_br)
                cause = CAUSE_BRANCH;
            else
                cause = CAUSE_RAW;
        end
    end
`endif

    assign stall = (cause != CAUSE_NONE);
    assign flush = br_taken && !stall && id_valid;
    assign push  = id_valid && !stall && id_wb_en && (id_dst != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid   <= '0;
            sb_is_load <= '0;
            sb_dst     <= '0;
        end else begin
            sb_valid   <= {sb_valid[DEPTH-2:0], push};
            sb_is_load <= {sb_is_load[DEPTH-2:0], push && id_is_load};
            sb_dst     <= {sb_dst[(DEPTH-1)*REG_ADDR_W-1:0], {REG_ADDR_W{push}} & id_dst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

`ifdef HAZARD_FWD_EN
    logic [SEL_W-1:0] fwd_next1, fwd_next2;

    // Entry i moves one stage on as the consumer enters EXE, so its result comes from stage i+1.
    assign fwd_next1 = (id_valid && !stall && act1) ? SEL_W'(idx1 + SEL_W'(1)) : SEL_W'(SEL_RF);
    assign fwd_next2 = (id_valid && !stall && act2) ? SEL_W'(idx2 + SEL_W'(1)) : SEL_W'(SEL_RF);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_sel1 <= '0;
            fwd_sel2 <= '0;
        end else begin
            fwd_sel1 <= fwd_next1;
            fwd_sel2 <= fwd_next2;
        end
    end
`else
    assign fwd_sel1 = '0;
    assign fwd_sel2 = '0;
`endif

endmodule
